// File: rtl/uart_word_packer_pkg.sv
// Shared types and helpers for the uart byte-to-word packer.
package uart_word_packer_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      ISSUE = 2'd2
   } state_t;

   function automatic logic [3:0] lane_be(input logic [1:0] lane);
      lane_be = 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/uart_word_packer_if.sv
// Byte-write stream in, word-write memory port out, plus packer status.
interface uart_word_packer_if #(
   parameter int CNT_W = 16
);
   import uart_word_packer_pkg::*;

   logic                     byte_valid;
   logic                     byte_ready;
   logic [BYTE_W-1:0]        byte_data;
   logic [WORD_W-1:0]        byte_addr;
   logic                     flush;
   logic                     mem_req;
   logic                     mem_ack;
   logic [WORD_W-1:0]        mem_addr;
   logic [WORD_W-1:0]        mem_wdata;
   logic [WORD_W/BYTE_W-1:0] mem_be;
   logic                     busy;
   logic [CNT_W-1:0]         words_written;

   modport master (
      output byte_valid, byte_data, byte_addr, flush, mem_ack,
      input  byte_ready, mem_req, mem_addr, mem_wdata, mem_be, busy, words_written
   );

   modport slave (
      input  byte_valid, byte_data, byte_addr, flush, mem_ack,
      output byte_ready, mem_req, mem_addr, mem_wdata, mem_be, busy, words_written
   );

endinterface

// File: rtl/uart_idle_timer.sv
// Idle counter: clear restarts it, enable advances it, expire flags TIMEOUT_CYCLES-1.
module uart_idle_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] count;

   assign expire = (count == CW'(TIMEOUT_CYCLES - 1));

   // Holds at the terminal value so a stalled owner never sees a wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expire) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/uart_word_packer.sv
// Merges uart byte writes into little-endian 32-bit word writes with byte enables.
//   state | meaning
//   EMPTY | no word held, any byte is accepted
//   FILL  | partial word held, same-tag bytes merge
//   ISSUE | word presented on mem port until ack
module uart_word_packer
   import uart_word_packer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   uart_word_packer_if.slave bus
);

   localparam int LANES = WORD_W / BYTE_W;

   state_t              state;
   logic [WORD_W-3:0]   tag;
   logic [WORD_W-1:0]   data;
   logic [LANES-1:0]    be;
   logic                mem_req;
   logic [CNT_W-1:0]    words_written;

   logic                accept;
   logic                tag_match;
   logic                expire;
   logic [1:0]          lane;
   logic [LANES-1:0]    be_next;

   assign lane      = bus.byte_addr[1:0];
   assign tag_match = (bus.byte_addr[WORD_W-1:2] == tag);
   assign be_next   = be | lane_be(lane);

   assign bus.byte_ready = (state == EMPTY) ||
                           ((state == FILL) && (!bus.byte_valid || tag_match));
   assign accept         = bus.byte_valid && bus.byte_ready;

   uart_idle_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk   (clk),
      .rst_n (reset),
      .clear (accept || (state != FILL)),
      .enable(state == FILL),
      .expire(expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= EMPTY;
         tag           <= '0;
         data          <= '0;
         be            <= '0;
         mem_req       <= 1'b0;
         words_written <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  tag                          <= bus.byte_addr[WORD_W-1:2];
                  data[lane*BYTE_W +: BYTE_W]  <= bus.byte_data;
                  be                           <= lane_be(lane);
                  state                        <= FILL;
               end
            end
            FILL: begin
               if (accept) begin
                  data[lane*BYTE_W +: BYTE_W] <= bus.byte_data;
                  be                          <= be_next;
               end
               // Without an accept, a valid byte here must carry a foreign tag.
               if (accept ? ((be_next == '1) || bus.flush)
                          : (bus.byte_valid || bus.flush || expire)) begin
                  state   <= ISSUE;
                  mem_req <= 1'b1;
               end
            end
            ISSUE: begin
               if (bus.mem_ack) begin
                  mem_req       <= 1'b0;
                  tag           <= '0;
                  data          <= '0;
                  be            <= '0;
                  words_written <= words_written + CNT_W'(1);
                  state         <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign bus.mem_req       = mem_req;
   assign bus.mem_addr      = {tag, 2'b00};
   assign bus.mem_wdata     = data;
   assign bus.mem_be        = be;
   assign bus.busy          = (state != EMPTY);
   assign bus.words_written = words_written;

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench for uart_word_packer with a write scoreboard on the mem port.
module tb_uart_word_packer;
   import uart_word_packer_pkg::*;

   localparam int TO = 8;
   localparam int CW = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } wr_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int  checks     = 0;
   int  passed     = 0;
   int  fails      = 0;
   int  writes     = 0;
   int  exp_writes = 0;
   wr_t exp_q[$];
   wr_t mon_e;

   always #5 clk = ~clk;

   uart_word_packer_if #(.CNT_W(CW)) bus ();

   uart_word_packer #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W         (CW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_write(input logic [31:0] a, input logic [31:0] w, input logic [3:0] b);
      exp_q.push_back(wr_t'({a, w, b}));
      exp_writes++;
   endtask

   task automatic send(input logic [31:0] a, input logic [7:0] d);
      int n;
      n = 0;
      bus.byte_valid = 1'b1;
      bus.byte_addr  = a;
      bus.byte_data  = d;
      #1;
      while (!bus.byte_ready && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      chk("accept_bound", 72'(n < 50), 72'(1));
      @(negedge clk); #1;
      bus.byte_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      bus.flush = 1'b1;
      @(negedge clk); #1;
      bus.flush = 1'b0;
   endtask

   task automatic wait_writes();
      int n;
      n = 0;
      while (writes < exp_writes && n < 100) begin
         @(negedge clk); #3;
         n++;
      end
      chk("write_bound", 72'(writes >= exp_writes), 72'(1));
      @(negedge clk); #1;
   endtask

   // Scoreboard: every completed handshake must match the oldest expected word.
   always @(negedge clk) begin
      #2;
      if (bus.mem_req && bus.mem_ack) begin
         writes++;
         chk("write_expected", 72'(exp_q.size() != 0), 72'(1));
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("write_word", 72'({bus.mem_addr, bus.mem_wdata, bus.mem_be}), 72'(mon_e));
         end
      end
   end

   initial begin
      logic [31:0] a, w;
      logic [7:0]  d;
      logic [3:0]  b;

      bus.byte_valid = 1'b0;
      bus.byte_addr  = '0;
      bus.byte_data  = '0;
      bus.flush      = 1'b0;
      bus.mem_ack    = 1'b1;

      #12;
      chk("reset_outputs", 72'({bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.busy}), 72'(0));
      chk("reset_count", 72'(bus.words_written), 72'(0));
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      chk("reset_ready", 72'(bus.byte_ready), 72'(1));

      // Full word on consecutive cycles
      expect_write(32'h100, 32'h44332211, 4'hF);
      send(32'h100, 8'h11);
      send(32'h101, 8'h22);
      send(32'h102, 8'h33);
      send(32'h103, 8'h44);
      chk("full_latency", 72'(bus.mem_req), 72'(1));
      wait_writes();
      chk("count_full", 72'(bus.words_written), 72'(1));

      // Tag change stalls the new byte and flushes the partial word
      expect_write(32'h204, 32'h0000AA00, 4'b0010);
      expect_write(32'h208, 32'h000000BB, 4'b0001);
      send(32'h205, 8'hAA);
      bus.byte_valid = 1'b1;
      bus.byte_addr  = 32'h208;
      bus.byte_data  = 8'hBB;
      #1;
      chk("tag_change_ready", 72'(bus.byte_ready), 72'(0));
      send(32'h208, 8'hBB);
      pulse_flush();
      wait_writes();
      chk("count_tag_change", 72'(bus.words_written), 72'(3));

      // Back-pressure from the memory with a byte waiting
      bus.mem_ack = 1'b0;
      expect_write(32'h300, 32'h64636261, 4'hF);
      send(32'h300, 8'h61);
      send(32'h301, 8'h62);
      send(32'h302, 8'h63);
      send(32'h303, 8'h64);
      bus.byte_valid = 1'b1;
      bus.byte_addr  = 32'h400;
      bus.byte_data  = 8'h77;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("stall_ready", 72'(bus.byte_ready), 72'(0));
         chk("stall_hold", 72'({bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_be}),
             72'({1'b1, 32'h300, 32'h64636261, 4'hF}));
      end
      bus.mem_ack = 1'b1;
      expect_write(32'h400, 32'h00000077, 4'b0001);
      send(32'h400, 8'h77);
      chk("stall_one_write", 72'(bus.words_written), 72'(4));
      pulse_flush();
      wait_writes();
      chk("count_stall", 72'(bus.words_written), 72'(5));

      // Idle timeout on a lone top-lane byte
      expect_write(32'h000, 32'h5A000000, 4'b1000);
      send(32'h003, 8'h5A);
      for (int k = 1; k <= TO; k++) begin
         @(negedge clk); #1;
         chk($sformatf("timeout_req_%0d", k), 72'(bus.mem_req), 72'(k == TO));
      end
      wait_writes();
      chk("count_timeout", 72'(bus.words_written), 72'(6));

      // Repeated lane overwrites data, enable unchanged
      expect_write(32'h010, 32'h00000002, 4'b0001);
      send(32'h010, 8'h01);
      send(32'h010, 8'h02);
      pulse_flush();
      wait_writes();
      chk("count_overwrite", 72'(bus.words_written), 72'(7));

      // Reset while three lanes are filled discards the word
      send(32'h500, 8'hC0);
      send(32'h501, 8'hC1);
      send(32'h502, 8'hC2);
      reset = 1'b0;
      #1;
      chk("midreset_outputs", 72'({bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.busy}), 72'(0));
      chk("midreset_count", 72'(bus.words_written), 72'(0));
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      chk("midreset_ready", 72'(bus.byte_ready), 72'(1));
      for (int i = 0; i < 2 * TO; i++) begin
         @(negedge clk); #1;
         chk("midreset_no_req", 72'(bus.mem_req), 72'(0));
      end
      expect_write(32'h600, 32'hA3A2A1A0, 4'hF);
      send(32'h600, 8'hA0);
      send(32'h601, 8'hA1);
      send(32'h602, 8'hA2);
      send(32'h603, 8'hA3);
      wait_writes();
      chk("count_after_reset", 72'(bus.words_written), 72'(1));

      // 16 more single-byte words wrap the counter back to 1
      for (int i = 0; i < (1 << CW); i++) begin
         a = 32'h1000 + 32'(4 * i + (i % 4));
         d = 8'(i + 1);
         w = 32'(d) << (8 * (i % 4));
         b = 4'b0001 << (i % 4);
         expect_write({a[31:2], 2'b00}, w, b);
         send(a, d);
      end
      pulse_flush();
      wait_writes();
      chk("count_wrap", 72'(bus.words_written), 72'(1));

      chk("scoreboard_empty", 72'(exp_q.size()), 72'(0));
      chk("write_total", 72'(writes), 72'(exp_writes));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
